alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have parameter NREGS, default 16, meaning register-file depth; only 16 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock with rising-edge active.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port instr_valid, input, 1, meaning an instruction word is offered.
REQ-005 The block SHALL have port instr_ready, output, 1, meaning the block can accept an instruction.
REQ-006 The block SHALL have port instr, input, 32, with fields cond[31:28], opcode[27:24], sbit[23], srcontrol[22:20], rd[19:16], imvalue[15:0], rn[15:12] and rm[11:8].
REQ-007 The block SHALL have ports alu_in1 and alu_in2, outputs, 32 each, carrying the R[rn] and R[rm] operands to the ALU.
REQ-008 The block SHALL have ports alu_cond (4), alu_opcode (4), alu_sbit (1), alu_srcontrol (3), alu_imvalue (16) and alu_inflags (4), all outputs, carrying the decoded fields and the flag register.
REQ-009 The block SHALL have ports alu_result, input, 32, and alu_outflags, input, 4, the combinational ALU result and flags {N,Z,C,V}.
REQ-010 The block SHALL have port flags, output, 4, the architectural flag register {N,Z,C,V}.
REQ-011 The block SHALL have ports wb_valid (1), wb_rd (4) and wb_data (32), outputs, reporting the writeback.
REQ-012 The block SHALL have port illegal, output, 1, a one-cycle pulse on an unsupported opcode.
REQ-013 The block SHALL have ports dbg_addr, input, 4, and dbg_data, output, 32, a combinational register read.

Function
REQ-014 The FSM SHALL have states IDLE, DECODE, EXEC and WB, with instr_ready=1 only in IDLE.
REQ-015 In IDLE, instr_valid&instr_ready at a clock edge SHALL latch instr and enter DECODE; otherwise the FSM stays in IDLE.
REQ-016 At the DECODE->EXEC edge, all alu_* outputs SHALL be registered from the latched fields, reading R[rn], R[rm] and flags; they hold stable through EXEC and WB.
REQ-017 In DECODE, cond SHALL be evaluated against flags: 0001 Z; 0010 !Z&(N==V); 0011 !Z&(N!=V); 0100 N==V; 0101 N!=V; 0110 !Z&C; 0111 !C; 1000 C; any other value is true.
REQ-018 EXEC SHALL always advance to WB; it is a settle cycle for the combinational ALU.
REQ-019 In WB, wb_valid SHALL be 1 for exactly one cycle, wb_rd=rd and wb_data=alu_result; writes and the flag update commit on the WB->IDLE edge.
REQ-020 Opcodes 0000-0111 with cond true SHALL write R[rd]=alu_result and, if sbit=1, set flags=alu_outflags.
REQ-021 Opcode 1000 (CMP) with cond true SHALL set flags=alu_outflags regardless of sbit and write no register.
REQ-022 Opcodes 1001, 1010 and 1111, and any opcode whose cond is false, SHALL change no register and no flags, and SHALL drive wb_valid=0 in WB.
REQ-023 Opcodes 1011-1110 SHALL pulse illegal in WB, write nothing, and drive wb_valid=0.
REQ-024 Instruction-to-writeback latency SHALL be 3 cycles after acceptance, with at most one instruction in flight and a throughput of one per 4 cycles.
REQ-025 An instruction whose rn or rm equals the previous rd SHALL read the updated value; no forwarding is needed because DECODE follows WB.
REQ-026 instr_valid asserted outside IDLE SHALL be ignored and SHALL not be latched.

Reset
REQ-027 Reset SHALL force, in any state, the next state to IDLE, all R[i]=0, flags=0, all alu_* outputs=0, and wb_valid=0, illegal=0, wb_rd=0 and wb_data=0.
REQ-028 Reset asserted mid-instruction SHALL discard the instruction with no register or flag commit; reset has priority over the WB commit.

Configuration
REQ-029 When macro ALU_ISSUE_R0_ZERO_EN is defined, R0 SHALL read as 0 and writes to R0 SHALL be dropped, although wb_valid still pulses.
REQ-030 When ALU_ISSUE_R0_ZERO_EN is undefined, R0 SHALL be an ordinary register.

Structure
REQ-031 Package alu_issue_pkg SHALL hold the opcode constants, cond codes, the FSM state enum, the instr field bit positions and the flag bit indices N=3, Z=2, C=1, V=0.
REQ-032 Sub-module reg_file SHALL implement 16x32 storage with two synchronous-use read ports, one debug read port and one write port, plus the R0 macro logic.

Verification
REQ-033 The bench SHALL cover: MOVN (0110) rd=1 imm=0x1234, then ADD rd=2 rn=1 rm=1 -> dbg R2=0x00002468, wb_valid pulse 3 cycles after each acceptance.
REQ-034 The bench SHALL cover: SUB sbit=1 rd=3 rn=1 rm=1 with a model ALU -> R3=0 and flags=4'b0100.
REQ-035 The bench SHALL cover: with Z=1, ADD cond=0001 writes, and ADD cond=0010 rd=4 leaves R4 unchanged with wb_valid=0.
REQ-036 The bench SHALL cover: opcode 1100 -> illegal=1 for exactly one cycle, with registers and flags unchanged.
REQ-037 The bench SHALL cover: reset pulsed during EXEC -> next cycle instr_ready=1, the target register remains 0, and flags=0.
REQ-038 The bench SHALL cover: instr_valid held high continuously -> acceptances exactly 4 cycles apart, and R0 behaviour checked with and without ALU_ISSUE_R0_ZERO_EN.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: opcode/cond constants, FSM states, instr field positions and flag indices
package alu_issue_pkg;
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
  localparam logic [3:0] OP_LAST_WR = 4'h7;
  localparam logic [3:0] OP_CMP     = 4'h8;
  localparam logic [3:0] OP_ILL_LO  = 4'hB;
  localparam logic [3:0] OP_ILL_HI  = 4'hE;
  localparam logic [3:0] CC_EQ   = 4'h1;
  localparam logic [3:0] CC_GT   = 4'h2;
  localparam logic [3:0] CC_LTNZ = 4'h3;
  localparam logic [3:0] CC_GE   = 4'h4;
  localparam logic [3:0] CC_LT   = 4'h5;
  localparam logic [3:0] CC_HI   = 4'h6;
  localparam logic [3:0] CC_CC   = 4'h7;
  localparam logic [3:0] CC_CS   = 4'h8;
  localparam int COND_LSB = 28;
  localparam int OPC_LSB  = 24;
  localparam int SBIT_BIT = 23;
  localparam int SRC_LSB  = 20;
  localparam int RD_LSB   = 16;
  localparam int RN_LSB   = 12;
  localparam int RM_LSB   = 8;
  localparam int FN = 3;
  localparam int FZ = 2;
  localparam int FC = 1;
  localparam int FV = 0;
  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    return c == CC_EQ   ? f[FZ] :
           c == CC_GT   ? !f[FZ] && (f[FN] == f[FV]) :
           c == CC_LTNZ ? !f[FZ] && (f[FN] != f[FV]) :
           c == CC_GE   ? f[FN] == f[FV] :
           c == CC_LT   ? f[FN] != f[FV] :
           c == CC_HI   ? !f[FZ] && f[FC] :
           c == CC_CC   ? !f[FC] :
           c == CC_CS   ? f[FC] : 1'b1;
  endfunction
endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction handshake plus the operand/result bus to the external ALU
interface alu_issue_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_cond;
  logic [3:0]  alu_opcode;
  logic        alu_sbit;
  logic [2:0]  alu_srcontrol;
  logic [15:0] alu_imvalue;
  logic [3:0]  alu_inflags;
  logic [31:0] alu_result;
  logic [3:0]  alu_outflags;
  modport master (
    output instr_valid, instr, alu_result, alu_outflags,
    input  instr_ready, alu_in1, alu_in2, alu_cond, alu_opcode, alu_sbit,
           alu_srcontrol, alu_imvalue, alu_inflags
  );
  modport slave (
    input  instr_valid, instr, alu_result, alu_outflags,
    output instr_ready, alu_in1, alu_in2, alu_cond, alu_opcode, alu_sbit,
           alu_srcontrol, alu_imvalue, alu_inflags
  );
endinterface

// File: rtl/alu_issue_reg_file.sv
// reg_file: 16x32 registers, two operand read ports, a debug read port, one write port; ALU_ISSUE_R0_ZERO_EN hardwires R0
module reg_file #(parameter int NREGS = 16) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [3:0]  da,
  output logic [31:0] rda,
  output logic [31:0] rdb,
  output logic [31:0] rdd,
  input  logic        we,
  input  logic [3:0]  wa,
  input  logic [31:0] wd
);
`ifdef ALU_ISSUE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif
  logic [31:0] regs [NREGS];
  // storage: cleared by reset, writes to a hardwired R0 are dropped
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (we && !(R0Z && wa == 4'd0)) regs[wa] <= wd;
  assign rda = (R0Z && ra == 4'd0) ? '0 : regs[ra];
  assign rdb = (R0Z && rb == 4'd0) ? '0 : regs[rb];
  assign rdd = (R0Z && da == 4'd0) ? '0 : regs[da];
endmodule

// File: rtl/alu_issue.sv
// alu_issue: 4-state issue/writeback sequencer for an external combinational ALU (ALU_ISSUE_R0_ZERO_EN: R0 reads 0)
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic        clk,
  input  logic        reset,
  alu_issue_if.slave  bus,
  output logic [3:0]  flags,
  output logic        wb_valid,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  state_t      state;
  logic [31:0] ir;
  logic [31:0] rn_data;
  logic [31:0] rm_data;
  logic        cond_ok;
  logic        we_q;
  logic        fl_q;
  logic [3:0]  of_q;
  logic        wr_op;
  logic        ill_op;
  assign bus.instr_ready = state == IDLE;
  assign wr_op  = bus.alu_opcode <= OP_LAST_WR;
  assign ill_op = bus.alu_opcode >= OP_ILL_LO && bus.alu_opcode <= OP_ILL_HI;
  reg_file #(.NREGS(NREGS)) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra    (ir[RN_LSB +: 4]),
    .rb    (ir[RM_LSB +: 4]),
    .da    (dbg_addr),
    .rda   (rn_data),
    .rdb   (rm_data),
    .rdd   (dbg_data),
    .we    (state == WB && we_q),
    .wa    (wb_rd),
    .wd    (wb_data)
  );
  // sequencer: latch, decode into ALU operands, capture ALU result, commit flags on leaving WB
  always_ff @(posedge clk)
    if (reset) begin
      state             <= IDLE;
      ir                <= '0;
      bus.alu_in1       <= '0;
      bus.alu_in2       <= '0;
      bus.alu_cond      <= '0;
      bus.alu_opcode    <= '0;
      bus.alu_sbit      <= 1'b0;
      bus.alu_srcontrol <= '0;
      bus.alu_imvalue   <= '0;
      bus.alu_inflags   <= '0;
      flags             <= '0;
      wb_valid          <= 1'b0;
      wb_rd             <= '0;
      wb_data           <= '0;
      illegal           <= 1'b0;
      cond_ok           <= 1'b0;
      we_q              <= 1'b0;
      fl_q              <= 1'b0;
      of_q              <= '0;
    end else case (state)
      IDLE: if (bus.instr_valid) begin
        ir    <= bus.instr;
        state <= DECODE;
      end
      DECODE: begin
        bus.alu_in1       <= rn_data;
        bus.alu_in2       <= rm_data;
        bus.alu_cond      <= ir[COND_LSB +: 4];
        bus.alu_opcode    <= ir[OPC_LSB +: 4];
        bus.alu_sbit      <= ir[SBIT_BIT];
        bus.alu_srcontrol <= ir[SRC_LSB +: 3];
        bus.alu_imvalue   <= ir[15:0];
        bus.alu_inflags   <= flags;
        cond_ok           <= cond_true(ir[COND_LSB +: 4], flags);
        state             <= EXEC;
      end
      EXEC: begin
        wb_valid <= cond_ok && (wr_op || bus.alu_opcode == OP_CMP);
        wb_rd    <= ir[RD_LSB +: 4];
        wb_data  <= bus.alu_result;
        illegal  <= ill_op;
        we_q     <= cond_ok && wr_op;
        fl_q     <= cond_ok && (bus.alu_opcode == OP_CMP || (wr_op && bus.alu_sbit));
        of_q     <= bus.alu_outflags;
        state    <= WB;
      end
      default: begin
        wb_valid <= 1'b0;
        illegal  <= 1'b0;
        flags    <= fl_q ? of_q : flags;
        state    <= IDLE;
      end
    endcase
endmodule
